canvas_streamer: RTL and testbench
==================================

CANVAS_STREAMER -- requirements
Module: canvas_streamer

Interface
REQ-001 SHALL have parameter GRID_SIZE, default 28: canvas edge length in cells.
REQ-002 SHALL have parameter INK_VALUE, default 8'hFF: out_data byte for an inked cell (1); a blank cell (0) SHALL map to 8'h00.
REQ-003 SHALL have port clock, input, 1: the single clock; all state SHALL be updated on its rising edge.
REQ-004 SHALL have port resetn, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1: frame request, sampled in IDLE only.
REQ-006 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-007 SHALL have port rd_addr, output, 10: canvas read address, row-major (y*GRID_SIZE + x).
REQ-008 SHALL have port rd_data, input, 1: canvas cell value, valid one cycle after rd_addr (synchronous read).
REQ-009 SHALL have port out_valid, output, 1: a pixel is presented.
REQ-010 SHALL have port out_ready, input, 1: the downstream network input buffer accepts.
REQ-011 SHALL have port out_data, output, 8: pixel intensity.
REQ-012 SHALL have port out_index, output, 10: address of the presented pixel.
REQ-013 SHALL have port out_last, output, 1: the presented pixel is index NUM_PIXELS-1.
REQ-014 SHALL have port done, output, 1: one-cycle pulse after the last transfer.
REQ-015 SHALL have port ink_count, output, 10: number of inked pixels in the current or last frame.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WAIT, SEND and FIN; NUM_PIXELS SHALL equal GRID_SIZE*GRID_SIZE (784 at default).
REQ-017 In IDLE with start=1 at edge k, SHALL clear the address counter to 0 and enter READ.
REQ-018 In IDLE, SHALL ignore start=0.
REQ-019 In READ, SHALL drive rd_addr with the counter value and then enter WAIT.
REQ-020 In WAIT, SHALL register rd_data-mapped byte into out_data and the counter into out_index, then enter SEND; out_valid SHALL therefore first rise after edge k+2.
REQ-021 In SEND, SHALL hold out_valid=1 with out_data, out_index and out_last stable until out_valid&&out_ready is sampled.
REQ-022 On a transfer of a non-last pixel, SHALL increment the counter and enter READ; minimum per-pixel period is 3 cycles.
REQ-023 On a transfer with out_last=1, SHALL enter FIN.
REQ-024 FIN SHALL assert done for exactly one cycle and then return to IDLE.
REQ-025 While busy, SHALL ignore start; a start held high across FIN SHALL begin a new frame no earlier than the cycle after return to IDLE.
REQ-026 The address counter SHALL never exceed NUM_PIXELS-1 and SHALL never wrap within a frame.
REQ-027 SHALL never assert out_valid outside SEND; out_ready outside SEND SHALL have no effect.
REQ-028 SHALL increment ink_count by 1 on each transfer whose cell was inked, SHALL clear it when a start is accepted, and SHALL hold it in IDLE.

Reset
REQ-029 On resetn=0 at any time, including mid-frame, SHALL enter IDLE immediately and clear the counter, out_data, out_index and ink_count to 0.
REQ-030 During reset, busy, out_valid, out_last and done SHALL all be 0.
REQ-031 After reset, SHALL not emit any pixel from an aborted frame.

Configuration
REQ-032 The macro CANVAS_INK_COUNT_EN SHALL control the ink counter.
REQ-033 With CANVAS_INK_COUNT_EN defined, ink_count SHALL behave per REQ-028.
REQ-034 Without CANVAS_INK_COUNT_EN, the ink_count port SHALL remain present and tied to 0, and SHALL add no counter logic; all other behaviour SHALL be identical.

Structure
REQ-035 Shared package canvas_pkg SHALL hold GRID_SIZE, NUM_PIXELS, ADDR_W=10 and the FSM state encoding, shared with the drawing/VGA stage.
REQ-036 The ink counter SHALL be the single sub-module canvas_ink_counter, instantiated only under CANVAS_INK_COUNT_EN.

Verification
REQ-037 Blank canvas, out_ready=1, pulse start -> 784 transfers of 8'h00 with indices 0..783; out_last only at 783; one done pulse; ink_count=0.
REQ-038 Canvas with cells 0, 406 and 783 inked -> out_data=8'hFF at exactly those indices; ink_count=3 after done.
REQ-039 out_ready toggled randomly -> no pixel is dropped or duplicated, and out_data/out_index are stable while stalled.
REQ-040 start re-pulsed at index 100 -> it is ignored and the frame completes normally.
REQ-041 resetn asserted at index 500 -> all outputs 0 immediately; a subsequent start restarts at index 0.
REQ-042 Back-to-back frames with start held high -> second frame begins after IDLE, and ink_count is cleared then recounted.

Source files
------------

// File: rtl/canvas_pkg.sv
// Shared canvas geometry and streamer FSM encoding, also used by the drawing/VGA stage.
package canvas_pkg;

  localparam int unsigned GRID_SIZE  = 28;
  localparam int unsigned NUM_PIXELS = GRID_SIZE * GRID_SIZE;
  localparam int unsigned ADDR_W     = 10;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StSend,
    StFin
  } canvas_state_e;

endpackage

// File: rtl/canvas_streamer_if.sv
// Pixel stream from the canvas streamer to the network input buffer (valid/ready).
interface canvas_streamer_if;
  import canvas_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/canvas_ink_counter.sv
// Counts inked pixels transferred in a frame; clear wins over increment.
module canvas_ink_counter
  import canvas_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W-1:0] count
);

  logic [ADDR_W-1:0] count_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + ADDR_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/canvas_streamer.sv
// Streams the canvas row-major into the network buffer, one pixel per valid/ready transfer.
// Build option: define CANVAS_INK_COUNT_EN to enable the ink counter (ink_count tied 0 otherwise).
module canvas_streamer #(
  parameter int unsigned GRID_SIZE = canvas_pkg::GRID_SIZE,
  parameter logic [7:0]  INK_VALUE = 8'hFF
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          start,
  output logic                          busy,
  output logic [canvas_pkg::ADDR_W-1:0] rd_addr,
  input  logic                          rd_data,
  canvas_streamer_if.master             pix,
  output logic                          done,
  output logic [canvas_pkg::ADDR_W-1:0] ink_count
);
  import canvas_pkg::*;

  localparam int unsigned     NumPixels = GRID_SIZE * GRID_SIZE;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NumPixels - 1);

  canvas_state_e     state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        data_q;
  logic [ADDR_W-1:0] index_q;
  logic              start_accept;
  logic              xfer;

  assign start_accept = (state_q == StIdle) && start;
  assign xfer         = (state_q == StSend) && pix.out_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StWait) begin
        data_q  <= rd_data ? INK_VALUE : 8'h00;
        index_q <= cnt_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d   = '0;
          state_d = StRead;
        end
      end
      StRead: state_d = StWait;
      StWait: state_d = StSend;
      StSend: begin
        if (pix.out_ready) begin
          // Counter only advances on a non-last transfer, so it never wraps.
          if (index_q == LastAddr) begin
            state_d = StFin;
          end else begin
            cnt_d   = cnt_q + ADDR_W'(1);
            state_d = StRead;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StFin);
  assign rd_addr       = cnt_q;
  assign pix.out_valid = (state_q == StSend);
  assign pix.out_data  = data_q;
  assign pix.out_index = index_q;
  assign pix.out_last  = (state_q == StSend) && (index_q == LastAddr);

`ifdef CANVAS_INK_COUNT_EN
  logic ink_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ink_q <= 1'b0;
    end else if (state_q == StWait) begin
      ink_q <= rd_data;
    end
  end

  canvas_ink_counter u_ink_counter (
    .clock  (clock),
    .resetn (resetn),
    .clear  (start_accept),
    .inc    (xfer && ink_q),
    .count  (ink_count)
  );
`else
  assign ink_count = '0;
`endif

endmodule

// File: tb/tb_canvas_streamer.sv
// Self-checking bench for canvas_streamer: frame-level model plus directed scenarios.
module tb_canvas_streamer;
  import canvas_pkg::*;

  localparam int         NP  = GRID_SIZE * GRID_SIZE;
  localparam logic [7:0] INK = 8'hFF;
`ifdef CANVAS_INK_COUNT_EN
  localparam bit InkEn = 1'b1;
`else
  localparam bit InkEn = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              resetn;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_data = 1'b0;
  logic [ADDR_W-1:0] ink_count;

  canvas_streamer_if pix ();

  canvas_streamer #(
    .GRID_SIZE (GRID_SIZE),
    .INK_VALUE (INK)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .busy      (busy),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .pix       (pix),
    .done      (done),
    .ink_count (ink_count)
  );

  always #5 clock = ~clock;

  bit canvas [NP];

  // Synchronous-read canvas memory.
  always @(posedge clock) rd_data <= (int'(rd_addr) < NP) ? canvas[rd_addr] : 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = random, other = never ready.
  int ready_mode = 0;
  initial begin
    pix.out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       pix.out_ready = 1'b1;
        1:       pix.out_ready = 1'($urandom_range(0, 1));
        default: pix.out_ready = 1'b0;
      endcase
    end
  end

  // Frame model: pixels must arrive in order 0..NP-1, each mapped from the canvas.
  bit         frame_active = 1'b0;
  int         exp_idx = 0;
  int         ink_model = 0;
  int         transfers = 0;
  int         done_cnt = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic [9:0] prev_index;
  int         hits[$];

  always @(negedge clock) begin
    if (!resetn) begin
      frame_active = 1'b0;
      exp_idx      = 0;
      ink_model    = 0;
      prev_stall   = 1'b0;
    end else begin
      chk("ink_count", 32'(ink_count), InkEn ? 32'(ink_model) : 32'd0);
      if (!pix.out_valid) chk("last_without_valid", 32'(pix.out_last), 0);
      if (pix.out_valid) begin
        if (!frame_active) chk("stray_valid", 1, 0);
        if (prev_stall) begin
          chk("stall_data", 32'(pix.out_data), 32'(prev_data));
          chk("stall_index", 32'(pix.out_index), 32'(prev_index));
        end
        if (pix.out_ready) begin
          if (exp_idx >= NP) begin
            chk("extra_pixel", 32'(exp_idx), NP - 1);
          end else begin
            chk("pix_index", 32'(pix.out_index), 32'(exp_idx));
            chk("pix_data", 32'(pix.out_data), canvas[exp_idx] ? 32'(INK) : 32'd0);
            chk("pix_last", 32'(pix.out_last), 32'(exp_idx == NP - 1));
            if (pix.out_data == INK) hits.push_back(int'(pix.out_index));
            if (canvas[exp_idx]) ink_model++;
          end
          exp_idx++;
          transfers++;
        end
        prev_stall = !pix.out_ready;
        prev_data  = pix.out_data;
        prev_index = pix.out_index;
      end else begin
        if (prev_stall) chk("valid_dropped_while_stalled", 1, 0);
        prev_stall = 1'b0;
      end
      if (done) begin
        if (!frame_active) chk("stray_done", 1, 0);
        chk("frame_len_at_done", 32'(exp_idx), NP);
        frame_active = 1'b0;
        done_cnt++;
      end
      if (!busy && start) begin
        frame_active = 1'b1;
        exp_idx      = 0;
        ink_model    = 0;
        transfers    = 0;
        hits.delete();
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_valid"}, 32'(pix.out_valid), 0);
    chk({tag, "_last"}, 32'(pix.out_last), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_data"}, 32'(pix.out_data), 0);
    chk({tag, "_index"}, 32'(pix.out_index), 0);
    chk({tag, "_ink"}, 32'(ink_count), 0);
  endtask

  // Pulse start and count edges until done; also returns the cycle out_valid first rose.
  task automatic run_frame(output int cyc, output int first_valid);
    bit seen;
    seen = 1'b0;
    cyc = 0;
    first_valid = 0;
    @(posedge clock);
    #1 start = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clock);
      cyc++;
      if (cyc == 1) #1 start = 1'b0;
      @(negedge clock);
      if (pix.out_valid && first_valid == 0) first_valid = cyc;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("run_frame_timeout", 0, 1);
  endtask

  task automatic wait_done(output int cyc);
    bit seen;
    seen = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("wait_done_timeout", 0, 1);
  endtask

  task automatic wait_idx(input int target);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clock);
      if (exp_idx >= target) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("wait_idx_timeout", 0, 1);
  endtask

  task automatic kick();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic after_done(input string tag, input int done_before, input int n);
    @(negedge clock);
    chk({tag, "_done_pulses"}, 32'(done_cnt - done_before), 32'(n));
    chk({tag, "_done_low"}, 32'(done), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    int cyc, fv, d0;
    resetn = 1'b0;
    start  = 1'b0;
    for (int i = 0; i < NP; i++) canvas[i] = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    @(posedge clock);
    #1 resetn = 1'b1;

    // Blank canvas, always ready: 3 cycles per pixel.
    d0 = done_cnt;
    run_frame(cyc, fv);
    chk("blank_first_valid_cycle", 32'(fv), 3);
    chk("blank_frame_cycles", 32'(cyc), 2353);
    chk("blank_transfers", 32'(transfers), NP);
    chk("blank_ink", 32'(ink_count), 0);
    chk("blank_hits", 32'(hits.size()), 0);
    after_done("blank", d0, 1);

    // Three inked cells at the corners and the centre.
    canvas[0] = 1'b1;
    canvas[406] = 1'b1;
    canvas[783] = 1'b1;
    d0 = done_cnt;
    run_frame(cyc, fv);
    chk("ink3_frame_cycles", 32'(cyc), 2353);
    chk("ink3_hit_count", 32'(hits.size()), 3);
    if (hits.size() == 3) begin
      chk("ink3_hit0", 32'(hits[0]), 0);
      chk("ink3_hit1", 32'(hits[1]), 406);
      chk("ink3_hit2", 32'(hits[2]), 783);
    end
    chk("ink3_ink_count", 32'(ink_count), InkEn ? 32'd3 : 32'd0);
    after_done("ink3", d0, 1);

    // Random backpressure with a striped canvas (i % 7 == 3 -> 112 inked cells).
    for (int i = 0; i < NP; i++) canvas[i] = (i % 7 == 3);
    ready_mode = 1;
    d0 = done_cnt;
    run_frame(cyc, fv);
    ready_mode = 0;
    chk("rand_transfers", 32'(transfers), NP);
    chk("rand_ink_count", 32'(ink_count), InkEn ? 32'd112 : 32'd0);
    after_done("rand", d0, 1);

    // Start re-pulsed mid-frame must be ignored.
    d0 = done_cnt;
    kick();
    wait_idx(100);
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(cyc);
    chk("repulse_transfers", 32'(transfers), NP);
    after_done("repulse", d0, 1);

    // Reset mid-frame, then restart from index 0.
    kick();
    wait_idx(500);
    @(posedge clock);
    #1 resetn = 1'b0;
    #1 check_all_zero("midreset");
    @(posedge clock);
    #1 resetn = 1'b1;
    repeat (5) @(negedge clock);
    chk("post_reset_no_valid", 32'(pix.out_valid), 0);
    d0 = done_cnt;
    run_frame(cyc, fv);
    chk("restart_first_valid_cycle", 32'(fv), 3);
    chk("restart_frame_cycles", 32'(cyc), 2353);
    chk("restart_transfers", 32'(transfers), NP);
    after_done("restart", d0, 1);

    // Start held high: second frame starts one cycle after returning to IDLE.
    for (int i = 0; i < NP; i++) canvas[i] = 1'b0;
    canvas[0] = 1'b1;
    canvas[406] = 1'b1;
    canvas[783] = 1'b1;
    d0 = done_cnt;
    @(posedge clock);
    #1 start = 1'b1;
    wait_done(cyc);
    chk("b2b_first_ink", 32'(ink_count), InkEn ? 32'd3 : 32'd0);
    wait_done(cyc);
    chk("b2b_gap_cycles", 32'(cyc), 2354);
    chk("b2b_second_ink", 32'(ink_count), InkEn ? 32'd3 : 32'd0);
    chk("b2b_transfers", 32'(transfers), NP);
    @(posedge clock);
    #1 start = 1'b0;
    after_done("b2b", d0, 2);

    repeat (4) @(negedge clock);
    chk("final_idle", 32'(busy), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
